// File: rtl/uparc_ifu.sv
// uparc_ifu: instruction fetch unit. It turns one-cycle fetch commands into
// held bus read requests, returns the fetched word, and flags misaligned
// addresses and bus errors with one-cycle pulses.
// Optional one-entry fetch buffer: define UPARC_IFU_BUF_EN to enable it.
module uparc_ifu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_rd_cmd,
  output logic [DATA_WIDTH-1:0] o_instr_dat,
  output logic                  o_busy,
  output logic                  o_err_align,
  output logic                  o_err_bus,
  input  logic                  i_buf_inv,
  output logic [ADDR_WIDTH-1:0] o_bus_addr,
  output logic                  o_bus_rd,
  input  logic                  i_bus_rdy,
  input  logic [DATA_WIDTH-1:0] i_bus_dat,
  input  logic                  i_bus_err
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  err_align_q, err_align_d;
  logic                  err_bus_q, err_bus_d;
  logic                  aligned;
  logic                  hit;
  logic [DATA_WIDTH-1:0] buf_dat;

  assign aligned = (i_addr[1:0] == 2'b00);

`ifdef UPARC_IFU_BUF_EN
  logic                  buf_vld_q, buf_vld_d;
  logic [ADDR_WIDTH-1:0] buf_tag_q, buf_tag_d;
  logic [DATA_WIDTH-1:0] buf_dat_q, buf_dat_d;

  // A hit needs a valid entry whose tag equals the requested address.
  assign hit     = buf_vld_q && (buf_tag_q == i_addr);
  assign buf_dat = buf_dat_q;

  // Buffer update: fill on clean completion, drop on bus error; invalidate wins.
  always_comb begin
    buf_vld_d = buf_vld_q;
    buf_tag_d = buf_tag_q;
    buf_dat_d = buf_dat_q;
    if (state_q == REQ && i_bus_rdy) begin
      if (i_bus_err) begin
        buf_vld_d = 1'b0;
      end else begin
        buf_vld_d = 1'b1;
        buf_tag_d = bus_addr_q;
        buf_dat_d = i_bus_dat;
      end
    end
    if (i_buf_inv) buf_vld_d = 1'b0;
  end

  // Buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld_q <= 1'b0;
      buf_tag_q <= '0;
      buf_dat_q <= '0;
    end else begin
      buf_vld_q <= buf_vld_d;
      buf_tag_q <= buf_tag_d;
      buf_dat_q <= buf_dat_d;
    end
  end
`else
  logic unused_buf_inv;

  assign hit            = 1'b0;
  assign buf_dat        = '0;
  assign unused_buf_inv = i_buf_inv;
`endif

  // Next-state and outputs: IDLE accepts commands, REQ holds the bus read.
  always_comb begin
    state_d     = state_q;
    bus_addr_d  = bus_addr_q;
    instr_d     = instr_q;
    err_align_d = 1'b0;
    err_bus_d   = 1'b0;
    o_busy      = 1'b0;
    o_bus_rd    = 1'b0;
    case (state_q)
      IDLE: begin
        o_busy = i_rd_cmd;
        if (i_rd_cmd) begin
          if (!aligned) begin
            instr_d     = '0;
            err_align_d = 1'b1;
          end else if (hit) begin
            instr_d = buf_dat;
          end else begin
            bus_addr_d = i_addr;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        o_busy   = 1'b1;
        o_bus_rd = 1'b1;
        if (i_bus_rdy) begin
          state_d = IDLE;
          if (i_bus_err) begin
            instr_d   = '0;
            err_bus_d = 1'b1;
          end else begin
            instr_d = i_bus_dat;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_addr_q  <= '0;
      instr_q     <= '0;
      err_align_q <= 1'b0;
      err_bus_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_addr_q  <= bus_addr_d;
      instr_q     <= instr_d;
      err_align_q <= err_align_d;
      err_bus_q   <= err_bus_d;
    end
  end

  assign o_bus_addr  = bus_addr_q;
  assign o_instr_dat = instr_q;
  assign o_err_align = err_align_q;
  assign o_err_bus   = err_bus_q;

endmodule

// File: tb/tb_uparc_ifu.sv
// Testbench for uparc_ifu: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a fetch-level model.
module tb_uparc_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_rd_cmd = 1'b0;
  logic [31:0] o_instr_dat;
  logic        o_busy;
  logic        o_err_align;
  logic        o_err_bus;
  logic        i_buf_inv = 1'b0;
  logic [31:0] o_bus_addr;
  logic        o_bus_rd;
  logic        i_bus_rdy = 1'b0;
  logic [31:0] i_bus_dat = '0;
  logic        i_bus_err = 1'b0;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  uparc_ifu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_rd_cmd(i_rd_cmd),
    .o_instr_dat(o_instr_dat), .o_busy(o_busy), .o_err_align(o_err_align),
    .o_err_bus(o_err_bus), .i_buf_inv(i_buf_inv), .o_bus_addr(o_bus_addr),
    .o_bus_rd(o_bus_rd), .i_bus_rdy(i_bus_rdy), .i_bus_dat(i_bus_dat),
    .i_bus_err(i_bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Fetch-level model: one outstanding fetch, last delivered word, pulse flags.
  bit          m_pend;
  logic [31:0] m_addr, m_instr, m_bt, m_bd;
  bit          m_ea, m_eb, m_bv;
  bit          buf_en;

  initial begin
`ifdef UPARC_IFU_BUF_EN
    buf_en = 1'b1;
`else
    buf_en = 1'b0;
`endif
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 0; m_addr = '0; m_instr = '0; m_ea = 0; m_eb = 0;
      m_bv = 0; m_bt = '0; m_bd = '0;
    end else begin
      m_ea = 0;
      m_eb = 0;
      if (m_pend) begin
        if (i_bus_rdy) begin
          m_pend = 0;
          if (i_bus_err) begin
            m_instr = '0; m_eb = 1; m_bv = 0;
          end else begin
            m_instr = i_bus_dat;
            if (buf_en) begin m_bv = 1; m_bt = m_addr; m_bd = i_bus_dat; end
          end
        end
      end else if (i_rd_cmd) begin
        if (i_addr % 4 != 0) begin
          m_instr = '0; m_ea = 1;
        end else if (buf_en && m_bv && m_bt == i_addr) begin
          m_instr = m_bd;
        end else begin
          m_pend = 1; m_addr = i_addr;
        end
      end
      if (buf_en && i_buf_inv) m_bv = 0;
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_bus_rd", o_bus_rd, m_pend);
      chk("m_bus_addr", o_bus_addr, m_addr);
      chk("m_busy", o_busy, m_pend | i_rd_cmd);
      chk("m_instr", o_instr_dat, m_instr);
      chk("m_err_align", o_err_align, m_ea);
      chk("m_err_bus", o_err_bus, m_eb);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d);
    cyc(); i_rd_cmd = 1; i_addr = a;
    cyc(); i_rd_cmd = 0; i_bus_rdy = 1; i_bus_dat = d;
    cyc(); i_bus_rdy = 0;
  endtask

  logic [31:0] addrs [6] = '{32'h100, 32'h104, 32'h108, 32'h102, 32'h101, 32'h200};

  initial begin
    #1 rst = 1;
    #1 cmp_en = 1;
    smp();
    chk("rst_instr", o_instr_dat, 32'h0);
    chk("rst_bus_addr", o_bus_addr, 32'h0);
    chk("rst_bus_rd", o_bus_rd, 1'b0);
    chk("rst_err", {o_err_align, o_err_bus}, 2'b00);
    cyc(); rst = 0;

    // Single-cycle bus response.
    cyc(); i_rd_cmd = 1; i_addr = 32'h100;
    smp(); chk("s1_busy_n", o_busy, 1'b1); chk("s1_rd_n", o_bus_rd, 1'b0);
    cyc(); i_rd_cmd = 0; i_bus_rdy = 1; i_bus_dat = 32'h2400_0001;
    smp(); chk("s1_rd_n1", o_bus_rd, 1'b1); chk("s1_addr_n1", o_bus_addr, 32'h100);
    chk("s1_busy_n1", o_busy, 1'b1);
    cyc(); i_bus_rdy = 0;
    smp(); chk("s1_instr_n2", o_instr_dat, 32'h2400_0001); chk("s1_busy_n2", o_busy, 1'b0);
    chk("s1_rd_n2", o_bus_rd, 1'b0);

    // Misaligned address.
    cyc(); i_rd_cmd = 1; i_addr = 32'h102;
    smp(); chk("al_rd_n", o_bus_rd, 1'b0);
    cyc(); i_rd_cmd = 0;
    smp(); chk("al_pulse", o_err_align, 1'b1); chk("al_instr", o_instr_dat, 32'h0);
    chk("al_rd_n1", o_bus_rd, 1'b0);
    cyc();
    smp(); chk("al_pulse_end", o_err_align, 1'b0);

    // Bus with three wait cycles (buffer invalidated first so 0x100 misses).
    cyc(); i_buf_inv = 1;
    cyc(); i_buf_inv = 0; i_rd_cmd = 1; i_addr = 32'h100;
    cyc(); i_rd_cmd = 0; i_bus_dat = 32'hA5A5_0003;
    for (int k = 0; k < 3; k++) begin
      smp(); chk("w_rd", o_bus_rd, 1'b1); chk("w_addr", o_bus_addr, 32'h100);
      chk("w_busy", o_busy, 1'b1);
      cyc();
    end
    i_bus_rdy = 1;
    smp(); chk("w_rd4", o_bus_rd, 1'b1);
    cyc(); i_bus_rdy = 0;
    smp(); chk("w_instr", o_instr_dat, 32'hA5A5_0003); chk("w_busy_end", o_busy, 1'b0);

    // Bus error.
    cyc(); i_rd_cmd = 1; i_addr = 32'h200;
    cyc(); i_rd_cmd = 0; i_bus_rdy = 1; i_bus_err = 1;
    smp(); chk("be_rd", o_bus_rd, 1'b1);
    cyc(); i_bus_rdy = 0; i_bus_err = 0;
    smp(); chk("be_pulse", o_err_bus, 1'b1); chk("be_instr", o_instr_dat, 32'h0);
    chk("be_idle", o_bus_rd, 1'b0); chk("be_busy", o_busy, 1'b0);
    cyc();
    smp(); chk("be_pulse_end", o_err_bus, 1'b0);

    // Reset during an outstanding request, then a stray completion.
    fetch(32'h104, 32'h1234_5678);
    smp(); chk("r_pre_instr", o_instr_dat, 32'h1234_5678);
    cyc(); i_rd_cmd = 1; i_addr = 32'h300;
    cyc(); i_rd_cmd = 0;
    smp(); chk("r_req", o_bus_rd, 1'b1);
    cyc(); rst = 1;
    smp(); chk("r_rd", o_bus_rd, 1'b0); chk("r_addr", o_bus_addr, 32'h0);
    chk("r_instr", o_instr_dat, 32'h0);
    cyc(); rst = 0; i_bus_rdy = 1; i_bus_dat = 32'hDEAD_BEEF;
    smp(); chk("r_stray_rd", o_bus_rd, 1'b0); chk("r_stray_busy", o_busy, 1'b0);
    cyc(); i_bus_rdy = 0;
    smp(); chk("r_stray_instr", o_instr_dat, 32'h0); chk("r_stray_err", o_err_bus, 1'b0);

`ifdef UPARC_IFU_BUF_EN
    // Buffer hit, then miss after invalidation.
    fetch(32'h100, 32'h1111_2222);
    cyc(); i_rd_cmd = 1; i_addr = 32'h101;
    cyc(); i_rd_cmd = 0;
    smp(); chk("b_cleared", o_instr_dat, 32'h0);
    cyc(); i_rd_cmd = 1; i_addr = 32'h100;
    smp(); chk("b_hit_busy_n", o_busy, 1'b1); chk("b_hit_rd_n", o_bus_rd, 1'b0);
    cyc(); i_rd_cmd = 0;
    smp(); chk("b_hit_instr", o_instr_dat, 32'h1111_2222); chk("b_hit_busy", o_busy, 1'b0);
    chk("b_hit_rd", o_bus_rd, 1'b0);
    cyc(); i_buf_inv = 1;
    cyc(); i_buf_inv = 0; i_rd_cmd = 1; i_addr = 32'h100;
    cyc(); i_rd_cmd = 0;
    smp(); chk("b_inv_rd", o_bus_rd, 1'b1);
    cyc(); i_bus_rdy = 1; i_bus_dat = 32'h3333_4444;
    cyc(); i_bus_rdy = 0;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst       = ($urandom_range(0, 199) == 0);
      i_rd_cmd  = ($urandom_range(0, 99) < 50);
      i_addr    = addrs[$urandom_range(0, 5)];
      i_bus_rdy = ($urandom_range(0, 99) < 40);
      i_bus_err = ($urandom_range(0, 99) < 20);
      i_bus_dat = $urandom;
      i_buf_inv = ($urandom_range(0, 99) < 8);
    end
    cyc();
    rst = 0; i_rd_cmd = 0; i_bus_rdy = 0; i_bus_err = 0; i_buf_inv = 0;
    repeat (3) cyc();
    smp();
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uparc_ifu.md
UPARC_IFU -- requirements
Module: uparc_ifu

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the instruction address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the instruction and bus data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, as listed in REQ-004 and REQ-005.
REQ-004 Port clk  in  1  is the clock; all state changes on the rising edge.
REQ-005 Port rst  in  1  is the asynchronous reset, active-high.
REQ-006 Port i_addr  in  ADDR_WIDTH  is the fetch address from the fetch stage.
REQ-007 Port i_rd_cmd  in  1  is a one-cycle read command from the fetch stage.
REQ-008 Port o_instr_dat  out  DATA_WIDTH  is the fetched instruction.
REQ-009 Port o_busy  out  1  is the fetch-in-progress stall to the fetch stage.
REQ-010 Port o_err_align  out  1  is a one-cycle misaligned-address pulse.
REQ-011 Port o_err_bus  out  1  is a one-cycle bus-error pulse.
REQ-012 Port i_buf_inv  in  1  invalidates the fetch buffer; it is ignored without UPARC_IFU_BUF_EN.
REQ-013 Port o_bus_addr  out  ADDR_WIDTH  is the bus read address.
REQ-014 Port o_bus_rd  out  1  is the bus read request, held until accepted.
REQ-015 Port i_bus_rdy  in  1  is the bus completion strobe; data or error is valid this cycle.
REQ-016 Port i_bus_dat  in  DATA_WIDTH  is the bus read data.
REQ-017 Port i_bus_err  in  1  is the bus error, qualified by i_bus_rdy.

Function
REQ-018 The FSM SHALL have two states: IDLE and REQ.
REQ-019 In IDLE, an i_rd_cmd with i_addr[1:0]==0 SHALL latch i_addr into o_bus_addr and enter REQ.
REQ-020 In REQ, o_bus_rd SHALL be 1 and o_bus_addr SHALL be stable until i_bus_rdy is sampled high.
REQ-021 On i_bus_rdy in REQ with i_bus_err low, o_instr_dat SHALL load i_bus_dat and the FSM SHALL enter IDLE.
REQ-022 On i_bus_rdy in REQ with i_bus_err high, o_instr_dat SHALL load 0 (NOP), o_err_bus SHALL pulse for exactly the next cycle, and the FSM SHALL enter IDLE.
REQ-023 An i_rd_cmd with i_addr[1:0]!=0 SHALL issue no bus request, SHALL load o_instr_dat with 0, and SHALL pulse o_err_align for exactly the next cycle.
REQ-024 o_busy SHALL be combinational: (state==REQ) OR (i_rd_cmd AND state==IDLE).
REQ-025 Latency: command in cycle N with i_bus_rdy high in N+1 SHALL give valid o_instr_dat and o_busy=0 in N+2.
REQ-026 Each bus wait cycle SHALL extend the latency in REQ-025 by one cycle.
REQ-027 o_instr_dat SHALL hold its value until the next completion, and is not cleared by the return to IDLE.
REQ-028 i_rd_cmd asserted while in REQ SHALL be ignored; the outstanding request SHALL complete unaffected.
REQ-029 i_bus_rdy sampled while in IDLE SHALL be ignored.

Reset
REQ-030 On rst, the FSM SHALL enter IDLE, and o_bus_rd, o_err_align, o_err_bus SHALL be 0.
REQ-031 On rst, o_bus_addr and o_instr_dat SHALL be 0, and the buffer SHALL be invalid.
REQ-032 Reset asserted during REQ SHALL abandon the request, and a late i_bus_rdy after reset release SHALL be ignored per REQ-029.

Configuration
REQ-033 With UPARC_IFU_BUF_EN defined, a one-entry buffer (tag, data, valid) SHALL be written on each error-free bus completion.
REQ-034 With UPARC_IFU_BUF_EN defined, an aligned command in IDLE whose address matches a valid tag SHALL issue no bus request.
REQ-035 On such a hit, o_instr_dat SHALL load the buffered data at cycle N+1, and o_busy SHALL be high only in cycle N.
REQ-036 With UPARC_IFU_BUF_EN defined, i_buf_inv or a bus error SHALL clear the buffer valid bit, and i_buf_inv SHALL take priority over a same-cycle fill.
REQ-037 Without UPARC_IFU_BUF_EN, every aligned command SHALL go to the bus and no buffer storage SHALL exist.

Verification
REQ-038 Scenario: cmd addr 0x100, rdy N+1 with data 0x2400_0001 -> o_bus_rd in N+1 only, busy in N and N+1, o_instr_dat=0x2400_0001 at N+2.
REQ-039 Scenario: cmd addr 0x100, bus waits 3 cycles -> o_bus_rd and o_bus_addr=0x100 held 4 cycles, busy high throughout, data at rdy+1.
REQ-040 Scenario: cmd addr 0x102 -> no o_bus_rd, o_err_align=1 at N+1 only, o_instr_dat=0.
REQ-041 Scenario: cmd addr 0x200, rdy with err -> o_err_bus=1 for one cycle, o_instr_dat=0, FSM in IDLE.
REQ-042 Scenario: rst pulsed in REQ, then stray rdy -> all outputs 0, stray rdy ignored.
REQ-043 Scenario (BUF_EN): fetch 0x100, refetch 0x100 -> no bus request, data at N+1; after i_buf_inv, refetch -> bus request issued.
